// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with reset vector, stall, absolute/PC-relative
// jumps and a hardware return-address stack for call/return.
//
// Command interface: the control unit presents one-cycle command strobes.
// A strobe sampled at a rising edge takes effect on that edge. There is no
// backpressure, so every command is either executed or dropped in the same
// cycle. Conflicting strobes are resolved by the fixed priority
//   rst > pc_stall > pc_ret > pc_call > pc_load > pc_inc > hold.
// Stack overflow (call when full) and underflow (ret when empty) leave the
// PC and the stack untouched and set the sticky stack_err flag.
module pc_stack_unit #(
  parameter int ADDR_W      = 16,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 8,
  parameter int INC_STEP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_stall,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              pc_call,
  input  logic              pc_ret,
  input  logic              pc_rel,
  input  logic [ADDR_W-1:0] target_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  // sp counts occupied entries, so it needs to represent 0..STACK_DEPTH.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]   SP_ZERO  = '0;
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INC_STEP);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_VEC);

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;

  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] ret_addr;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              is_full;
  logic              is_empty;

  logic [ADDR_W-1:0] pc_next;
  logic [SP_W-1:0]   sp_next;
  logic              err_next;
  logic              push_en;

  // Operand and stack-pointer decode shared by the command logic.
  always_comb begin
    tgt      = pc_rel ? (pc_addr + target_addr) : target_addr;
    ret_addr = pc_addr + STEP;
    is_full  = (sp == SP_FULL);
    is_empty = (sp == SP_ZERO);
    // Index casts only matter when sp is in range; the full/empty guards
    // below keep out-of-range values from ever being used.
    wr_idx   = IDX_W'(sp);
    rd_idx   = IDX_W'(sp - SP_ONE);
  end

  // Priority command resolution: computes next PC, next sp and error update.
  always_comb begin
    pc_next  = pc_addr;
    sp_next  = sp;
    err_next = stack_err;
    push_en  = 1'b0;
    if (pc_stall) begin
      // Everything frozen, including the sticky error.
      pc_next = pc_addr;
    end else if (pc_ret) begin
      if (is_empty) begin
        err_next = 1'b1;
      end else begin
        pc_next = stack_mem[rd_idx];
        sp_next = sp - SP_ONE;
      end
    end else if (pc_call) begin
      if (is_full) begin
        err_next = 1'b1;
      end else begin
        push_en = 1'b1;
        pc_next = tgt;
        sp_next = sp + SP_ONE;
      end
    end else if (pc_load) begin
      pc_next = tgt;
    end else if (pc_inc) begin
      pc_next = pc_addr + STEP;
    end
  end

  // PC, stack pointer, sticky error and registered full/empty flags.
  // Flags are registered from sp_next so they always agree with sp.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_addr     <= PC_RESET;
      sp          <= SP_ZERO;
      stack_err   <= 1'b0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
    end else begin
      pc_addr     <= pc_next;
      sp          <= sp_next;
      stack_err   <= err_next;
      stack_full  <= (sp_next == SP_FULL);
      stack_empty <= (sp_next == SP_ZERO);
    end
  end

  // Return-address storage; contents need no reset because sp guards reads.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_mem[wr_idx] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed-vector bench for pc_stack_unit with default
// parameters (16-bit, reset vector 0, 8-entry stack, step 1).
module tb_pc_stack_unit;

  logic        clk;
  logic        rst;
  logic        pc_stall;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_call;
  logic        pc_ret;
  logic        pc_rel;
  logic [15:0] target_addr;
  logic [15:0] pc_addr;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected return addresses (LIFO).
  logic [15:0] exp_q[$];

  pc_stack_unit dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .pc_load(pc_load),
    .pc_inc(pc_inc), .pc_call(pc_call), .pc_ret(pc_ret), .pc_rel(pc_rel),
    .target_addr(target_addr), .pc_addr(pc_addr), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: apply one cycle of command strobes, then sample 1 ns after the edge.
  task automatic drive(input logic r, input logic st, input logic ld,
                       input logic inc, input logic cl, input logic rt,
                       input logic rl, input logic [15:0] t);
    @(negedge clk);
    rst = r; pc_stall = st; pc_load = ld; pc_inc = inc;
    pc_call = cl; pc_ret = rt; pc_rel = rl; target_addr = t;
    @(posedge clk);
    #1;
    rst = 1'b0; pc_stall = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
    pc_call = 1'b0; pc_ret = 1'b0; pc_rel = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 0, 0, 0, 0, 16'h1234);
    drive(1, 0, 1, 0, 0, 0, 0, 16'h1234);
    checks++; if (pc_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc_addr); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", stack_empty); end
    checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", stack_full); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", stack_err); end
  endtask

  task automatic test_inc_wrap();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    drive(0, 0, 1, 0, 0, 0, 0, 16'hFFFE);
    checks++; if (pc_addr !== exp_pc[0]) begin errors++; $display("FAIL load_abs: got %h expected %h", pc_addr, exp_pc[0]); end
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 16'h0000);
      checks++; if (pc_addr !== exp_pc[i]) begin errors++; $display("FAIL inc_wrap_%0d: got %h expected %h", i, pc_addr, exp_pc[i]); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 16'hABCD);
    checks++; if (pc_addr !== 16'h0001) begin errors++; $display("FAIL hold: got %h expected 0001", pc_addr); end
  endtask

  task automatic test_call_ret();
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0010);
    drive(0, 0, 0, 0, 1, 0, 0, 16'h0200);
    checks++; if (pc_addr !== 16'h0200) begin errors++; $display("FAIL call_pc: got %h expected 0200", pc_addr); end
    checks++; if (stack_empty !== 1'b0) begin errors++; $display("FAIL call_empty: got %b expected 0", stack_empty); end
    drive(0, 0, 0, 0, 0, 1, 0, 16'h0000);
    checks++; if (pc_addr !== 16'h0011) begin errors++; $display("FAIL ret_pc: got %h expected 0011", pc_addr); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b expected 1", stack_empty); end
  endtask

  task automatic test_rel();
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0100);
    drive(0, 0, 1, 0, 0, 0, 1, 16'hFFF0);
    checks++; if (pc_addr !== 16'h00F0) begin errors++; $display("FAIL load_rel: got %h expected 00F0", pc_addr); end
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0100);
    drive(0, 0, 0, 0, 1, 0, 1, 16'h0004);
    checks++; if (pc_addr !== 16'h0104) begin errors++; $display("FAIL call_rel: got %h expected 0104", pc_addr); end
    drive(0, 0, 0, 0, 0, 1, 0, 16'h0000);
    checks++; if (pc_addr !== 16'h0101) begin errors++; $display("FAIL call_rel_ret: got %h expected 0101", pc_addr); end
  endtask

  task automatic test_stack_fill();
    logic [15:0] cur;
    logic [15:0] t;
    logic [15:0] exp_ret;
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0020);
    cur = 16'h0020;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      t = 16'h1000 + 16'(i * 16);
      exp_q.push_back(cur + 16'h0001);
      drive(0, 0, 0, 0, 1, 0, 0, t);
      cur = t;
      checks++; if (pc_addr !== t) begin errors++; $display("FAIL fill_call_%0d: got %h expected %h", i, pc_addr, t); end
    end
    checks++; if (stack_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", stack_full); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL fill_err_clear: got %b expected 0", stack_err); end
    drive(0, 0, 0, 0, 1, 0, 0, 16'h2000);
    checks++; if (pc_addr !== 16'h1070) begin errors++; $display("FAIL overflow_pc: got %h expected 1070", pc_addr); end
    checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", stack_err); end
    checks++; if (stack_full !== 1'b1) begin errors++; $display("FAIL overflow_full: got %b expected 1", stack_full); end
    for (int i = 0; i < 8; i++) begin
      exp_ret = exp_q.pop_back();
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0000);
      checks++; if (pc_addr !== exp_ret) begin errors++; $display("FAIL lifo_ret_%0d: got %h expected %h", i, pc_addr, exp_ret); end
    end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", stack_empty); end
    drive(0, 0, 0, 0, 0, 1, 0, 16'h0000);
    checks++; if (pc_addr !== 16'h0021) begin errors++; $display("FAIL underflow_pc: got %h expected 0021", pc_addr); end
    checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b expected 1", stack_err); end
  endtask

  task automatic test_stall_priority();
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL rst_clears_err: got %b expected 0", stack_err); end
    drive(0, 1, 0, 0, 0, 1, 0, 16'h0000);
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL stall_no_underflow: got %b expected 0", stack_err); end
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0300);
    drive(0, 0, 0, 0, 1, 0, 0, 16'h0400);
    drive(0, 1, 1, 1, 1, 1, 0, 16'h0500);
    checks++; if (pc_addr !== 16'h0400) begin errors++; $display("FAIL stall_pc: got %h expected 0400", pc_addr); end
    checks++; if (stack_empty !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b expected 0", stack_empty); end
    drive(0, 0, 1, 1, 1, 1, 0, 16'h0500);
    checks++; if (pc_addr !== 16'h0301) begin errors++; $display("FAIL ret_wins: got %h expected 0301", pc_addr); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL ret_wins_empty: got %b expected 1", stack_empty); end
    drive(0, 0, 1, 1, 1, 0, 0, 16'h0600);
    checks++; if (pc_addr !== 16'h0600) begin errors++; $display("FAIL call_over_load: got %h expected 0600", pc_addr); end
    drive(0, 0, 1, 1, 0, 0, 0, 16'h0700);
    checks++; if (pc_addr !== 16'h0700) begin errors++; $display("FAIL load_over_inc: got %h expected 0700", pc_addr); end
    drive(1, 1, 0, 0, 1, 0, 0, 16'h0800);
    checks++; if (pc_addr !== 16'h0000) begin errors++; $display("FAIL mid_rst_pc: got %h expected 0000", pc_addr); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: got %b expected 1", stack_empty); end
    checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL mid_rst_full: got %b expected 0", stack_full); end
  endtask

  initial begin
    rst = 1'b1; pc_stall = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
    pc_call = 1'b0; pc_ret = 1'b0; pc_rel = 1'b0; target_addr = 16'h0000;
    test_reset();
    test_inc_wrap();
    test_call_ret();
    test_rel();
    test_stack_fill();
    test_stall_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
